// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg -- shared types for the write-back arbiter.
//   XLEN     : data width of a register file write
//   RAW      : register address width
//   wb_req_t : one pending write-back {rd, data}
package wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int RAW  = 5;

  typedef struct packed {
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- DEPTH-entry FIFO of wb_req_t for buffered load results.
// Ports:
//   clk, clr      : clock, async active-high clear (drops all entries)
//   push, din     : write an entry (caller guarantees not full)
//   pop, head     : head entry, removed by pop (caller guarantees not empty)
//   full, empty   : occupancy flags
//   count         : current occupancy, 0..DEPTH
import wb_arbiter_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        push,
  input  wb_req_t     din,
  input  logic        pop,
  output wb_req_t     head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      if (pop)  r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
      if (push && !pop)      r_count <= (AW+1)'(r_count + 1'b1);
      else if (pop && !push) r_count <= (AW+1)'(r_count - 1'b1);
    end
  end

  // Storage needs no reset: contents are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter -- merges ALU and buffered load results onto one registered
// register-file write port.
// Priority: full load buffer > ALU offer > non-empty load buffer.
// Ports:
//   clk, clr                          : clock, async active-high reset
//   alu_valid/alu_rd/alu_result       : ALU offer, held while alu_stall=1
//   alu_stall                         : ALU offer not taken this cycle
//   lsu_valid/lsu_rd/lsu_data         : load offer, accepted when lsu_ready
//   lsu_ready                         : load buffer not full
//   we/write_addr/result              : registered regfile write port
//   source_a/source_b                 : regfile read addresses for bypass
//   fwd_a/fwd_b/fwd_data_a/fwd_data_b : bypass hit and data
// Build option: WB_BYPASS_EN enables the bypass compare; otherwise the
// fwd_* outputs are tied to zero.
import wb_arbiter_pkg::*;

module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            alu_valid,
  input  logic [RAW-1:0]  alu_rd,
  input  logic [XLEN-1:0] alu_result,
  output logic            alu_stall,
  input  logic            lsu_valid,
  input  logic [RAW-1:0]  lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we,
  output logic [RAW-1:0]  write_addr,
  output logic [XLEN-1:0] result,
  input  logic [RAW-1:0]  source_a,
  input  logic [RAW-1:0]  source_b,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic [XLEN-1:0] fwd_data_a,
  output logic [XLEN-1:0] fwd_data_b
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t         w_head;
  wb_req_t         w_win;
  logic            w_win_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [AW:0]     w_count;

  logic            r_we;
  logic [RAW-1:0]  r_waddr;
  logic [XLEN-1:0] r_result;

  assign lsu_ready = (w_count != (AW+1)'(DEPTH));
  assign w_push    = lsu_valid && lsu_ready;
  assign alu_stall = w_full && alu_valid;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (w_push),
    .din   ('{rd: lsu_rd, data: lsu_data}),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // A full buffer must drain first, otherwise loads could starve behind a
  // continuously busy ALU.
  always_comb begin
    w_win_valid = 1'b0;
    w_win       = '0;
    w_pop       = 1'b0;
    if (w_full) begin
      w_win_valid = 1'b1;
      w_win       = w_head;
      w_pop       = 1'b1;
    end else if (alu_valid) begin
      w_win_valid = 1'b1;
      w_win       = '{rd: alu_rd, data: alu_result};
    end else if (!w_empty) begin
      w_win_valid = 1'b1;
      w_win       = w_head;
      w_pop       = 1'b1;
    end
  end

  // Writes to x0 are consumed but suppressed; address/data hold otherwise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_result <= '0;
    end else if (w_win_valid && (w_win.rd != '0)) begin
      r_we     <= 1'b1;
      r_waddr  <= w_win.rd;
      r_result <= w_win.data;
    end else begin
      r_we     <= 1'b0;
    end
  end

  assign we         = r_we;
  assign write_addr = r_waddr;
  assign result     = r_result;

`ifdef WB_BYPASS_EN
  assign fwd_a      = r_we && (r_waddr == source_a) && (source_a != '0);
  assign fwd_b      = r_we && (r_waddr == source_b) && (source_b != '0);
  assign fwd_data_a = r_result;
  assign fwd_data_b = r_result;
`else
  logic w_unused_src;
  assign w_unused_src = ^{source_a, source_b};
  assign fwd_a      = 1'b0;
  assign fwd_b      = 1'b0;
  assign fwd_data_a = '0;
  assign fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
import wb_arbiter_pkg::*;

module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        we;
  logic [4:0]  write_addr;
  logic [31:0] result;
  logic [4:0]  source_a, source_b;
  logic        fwd_a, fwd_b;
  logic [31:0] fwd_data_a, fwd_data_b;

  int checks = 0;
  int failures = 0;

  // Reference model: buffered loads as a plain queue plus the write port.
  wb_req_t     m_q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we(we), .write_addr(write_addr), .result(result),
    .source_a(source_a), .source_b(source_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_we = 1'b0;
    m_addr = '0;
    m_res = '0;
  endtask

  // One cycle: drive, check combinational outputs, clock, check write port.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] sa, input logic [4:0] sb, output logic stalled);
    bit      full, have;
    wb_req_t w;
    logic    efa, efb;
    alu_valid = av; alu_rd = ard; alu_result = ares;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    source_a = sa; source_b = sb;
    #1;
    full = (m_q.size() == DEPTH);
    stalled = full && av;
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, !full});
    chk("alu_stall", {31'd0, alu_stall}, {31'd0, stalled});
`ifdef WB_BYPASS_EN
    efa = m_we && (m_addr == sa) && (sa != 5'd0);
    efb = m_we && (m_addr == sb) && (sb != 5'd0);
    chk("fwd_a", {31'd0, fwd_a}, {31'd0, efa});
    chk("fwd_b", {31'd0, fwd_b}, {31'd0, efb});
    chk("fwd_data_a", fwd_data_a, m_res);
    chk("fwd_data_b", fwd_data_b, m_res);
`else
    efa = 1'b0; efb = 1'b0;
    chk("fwd_off", {30'd0, fwd_a, fwd_b}, {30'd0, efa, efb});
    chk("fwd_data_off", fwd_data_a | fwd_data_b, 32'd0);
`endif
    have = 1'b0;
    w = '0;
    if (full) begin
      w = m_q.pop_front(); have = 1'b1;
    end else if (av) begin
      w.rd = ard; w.data = ares; have = 1'b1;
    end else if (m_q.size() > 0) begin
      w = m_q.pop_front(); have = 1'b1;
    end
    if (lv && !full) m_q.push_back('{rd: lrd, data: ldat});
    @(posedge clk);
    #1;
    if (have && w.rd != 5'd0) begin
      m_we = 1'b1; m_addr = w.rd; m_res = w.data;
    end else begin
      m_we = 1'b0;
    end
    chk("we", {31'd0, we}, {31'd0, m_we});
    chk("write_addr", {27'd0, write_addr}, {27'd0, m_addr});
    chk("result", result, m_res);
  endtask

  task automatic idle(input int n);
    logic s;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  initial begin
    logic        s, hold;
    logic        av, lv;
    logic [4:0]  ard, lrd, sa, sb;
    logic [31:0] ares, ldat;

    clr = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    source_a = 0; source_b = 0;
    model_reset();
    #3;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", {27'd0, write_addr}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_stall", {31'd0, alu_stall}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // ALU only
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, s);
    chk("alu_we", {31'd0, we}, 32'd1);
    chk("alu_addr", {27'd0, write_addr}, 32'd5);
    chk("alu_data", result, 32'hDEADBEEF);

    // Bypass compare against the held write port
    step(0, 0, 0, 0, 0, 0, 5'd5, 5'd0, s);
    step(1, 5'd7, 32'h0000_7777, 0, 0, 0, 0, 0, s);
    step(0, 0, 0, 0, 0, 0, 5'd7, 5'd0, s);

    // Conflict: ALU first, load one cycle later
    step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, s);
    chk("conf_x3", {write_addr, result[26:0]}, {5'd3, 27'h11});
    step(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("conf_x4", {write_addr, result[26:0]}, {5'd4, 27'h22});
    idle(2);

    // Full buffer with ALU busy every cycle
    step(1, 5'd10, 32'hA0, 1, 5'd20, 32'hB0, 0, 0, s);
    step(1, 5'd11, 32'hA1, 1, 5'd21, 32'hB1, 0, 0, s);
    chk("full_ready", {31'd0, lsu_ready}, 32'd0);
    step(1, 5'd12, 32'hA2, 0, 0, 0, 0, 0, s);
    chk("full_head", {write_addr, result[26:0]}, {5'd20, 27'hB0});
    step(1, 5'd12, 32'hA2, 0, 0, 0, 0, 0, s);
    chk("full_alu", {write_addr, result[26:0]}, {5'd12, 27'hA2});
    step(1, 5'd13, 32'hA3, 0, 0, 0, 0, 0, s);
    step(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("full_tail", {write_addr, result[26:0]}, {5'd21, 27'hB1});
    idle(1);

    // x0 load is consumed without a write
    step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, s);
    step(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("x0_we", {31'd0, we}, 32'd0);
    chk("x0_empty", {31'd0, lsu_ready}, 32'd1);
    idle(1);

    // Reset with two entries buffered
    step(1, 5'd9, 32'h99, 1, 5'd14, 32'hC0, 0, 0, s);
    step(1, 5'd8, 32'h88, 1, 5'd15, 32'hC1, 0, 0, s);
    chk("pre_rst_full", {31'd0, lsu_ready}, 32'd0);
    alu_valid = 0; lsu_valid = 0;
    clr = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, alu_stall}, 32'd0);
    chk("mid_rst_addr", {27'd0, write_addr}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    idle(4);

    // Randomized traffic
    hold = 1'b0;
    av = 0; ard = 0; ares = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        av   = ($urandom % 4) != 0;
        ard  = 5'($urandom_range(0, 31));
        ares = $urandom;
      end
      lv   = ($urandom % 2) != 0;
      lrd  = 5'($urandom_range(0, 31));
      ldat = $urandom;
      sa   = (($urandom % 2) != 0) ? m_addr : 5'($urandom_range(0, 31));
      sb   = (($urandom % 3) == 0) ? m_addr : 5'($urandom_range(0, 31));
      step(av, ard, ares, lv, lrd, ldat, sa, sb, s);
      hold = s;
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
